// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clock on sout,
// sout_valid qualifier and a one-cycle done pulse, with gapless back-to-back reload.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             last_bit;
    logic             accept;

    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_BIT);
    // Ready during the last bit lets the next word follow with no idle gap.
    assign load_ready = (state_q == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // Zero fill leaves the register clear once a word has been fully shifted out.
    assign shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

    // NOTE: reset is in the sensitivity list so assertion clears the frame without waiting for clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            done_q <= last_bit;
            if (accept) begin
                shreg_q <= load_data;
                cnt_q   <= '0;
                state_q <= SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_q <= shreg_d;
                if (last_bit) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign sout_valid = (state_q == SHIFT);
    assign sout       = sout_valid & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus; a cycle-stamped
// scoreboard of expected bits and done pulses is checked on every falling edge.
module tb_piso_shift_tx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;

    logic rdy_m, sout_m, sv_m, done_m;
    logic rdy_l, sout_l, sv_l, done_l;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .resetn(resetn), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .done(done_m)
    );

    piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .resetn(resetn), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .done(done_l)
    );

    // Expected serial bit for the cycle that begins at edge number cyc.
    typedef struct {
        int   cyc;
        logic bm;
        logic bl;
        logic last;
    } bit_t;

    // Serial sequences are written first-transmitted bit on the left.
    typedef struct {
        logic [7:0] data;
        logic       b2b;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    bit_t bq[$];
    int   dq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    vec_t vecs[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_sv_msb"},   {31'd0, sv_m},   32'd0);
        check({tag, "_sout_msb"}, {31'd0, sout_m}, 32'd0);
        check({tag, "_done_msb"}, {31'd0, done_m}, 32'd0);
        check({tag, "_rdy_msb"},  {31'd0, rdy_m},  32'd1);
        check({tag, "_sv_lsb"},   {31'd0, sv_l},   32'd0);
        check({tag, "_sout_lsb"}, {31'd0, sout_l}, 32'd0);
        check({tag, "_done_lsb"}, {31'd0, done_l}, 32'd0);
        check({tag, "_rdy_lsb"},  {31'd0, rdy_l},  32'd1);
    endtask

    // Called at a falling edge while the block is known to be ready; the word is accepted
    // at the next rising edge.
    task automatic push_word(input logic [7:0] em, input logic [7:0] el);
        int base;
        base = cyc + 1;
        for (int i = 0; i < WIDTH; i++) begin
            bq.push_back('{base + i, em[7-i], el[7-i], (i == WIDTH - 1)});
        end
        dq.push_back(base + WIDTH);
    endtask

    // Leaves the caller at the falling edge inside the word's last-bit cycle.
    task automatic send_word(input vec_t v);
        if (!v.b2b) repeat (3) @(negedge clk);
        load_valid = 1'b1;
        load_data  = v.data;
        push_word(v.exp_msb, v.exp_lsb);
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        repeat (WIDTH - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        bit_t e;
        logic exp_v;
        logic exp_last;
        logic exp_d;
        if (mon_en && resetn) begin
            exp_v    = 1'b0;
            exp_last = 1'b0;
            e        = '{0, 1'b0, 1'b0, 1'b0};
            if (bq.size() > 0 && bq[0].cyc == cyc) begin
                e        = bq.pop_front();
                exp_v    = 1'b1;
                exp_last = e.last;
            end
            check("sout_valid_msb", {31'd0, sv_m}, {31'd0, exp_v});
            check("sout_valid_lsb", {31'd0, sv_l}, {31'd0, exp_v});
            check("sout_msb", {31'd0, sout_m}, {31'd0, exp_v & e.bm});
            check("sout_lsb", {31'd0, sout_l}, {31'd0, exp_v & e.bl});
            check("load_ready_msb", {31'd0, rdy_m}, {31'd0, !exp_v || exp_last});
            check("load_ready_lsb", {31'd0, rdy_l}, {31'd0, !exp_v || exp_last});
            exp_d = (dq.size() > 0 && dq[0] == cyc);
            if (exp_d) void'(dq.pop_front());
            check("done_msb", {31'd0, done_m}, {31'd0, exp_d});
            check("done_lsb", {31'd0, done_l}, {31'd0, exp_d});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'b10100101, 8'b10100101};
        vecs[1] = '{8'h3C, 1'b1, 8'b00111100, 8'b00111100};
        vecs[2] = '{8'h01, 1'b0, 8'b00000001, 8'b10000000};
        vecs[3] = '{8'hC8, 1'b0, 8'b11001000, 8'b00010011};
        vecs[4] = '{8'h96, 1'b1, 8'b10010110, 8'b01101001};
        vecs[5] = '{8'hFF, 1'b1, 8'b11111111, 8'b11111111};
        vecs[6] = '{8'h80, 1'b1, 8'b10000000, 8'b00000001};
        vecs[7] = '{8'h0F, 1'b0, 8'b00001111, 8'b11110000};

        // Reset held with random inputs toggling.
        repeat (5) begin
            @(negedge clk);
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 8'($urandom);
            #1 check_reset_outs("in_reset");
        end
        @(negedge clk);
        load_valid = 1'b0;
        #1 resetn = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Single words, back-to-back pairs and a continuous chain.
        for (int i = 0; i < 7; i++) send_word(vecs[i]);

        // Loads offered while busy must be ignored.
        repeat (3) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hA5;
        push_word(8'b10100101, 8'b10100101);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        repeat (4) @(negedge clk);
        load_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during bit 3 of a frame: immediate abort, no done pulse.
        load_valid = 1'b1;
        load_data  = 8'hA5;
        push_word(8'b10100101, 8'b10100101);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        bq.delete();
        dq.delete();
        #1 check_reset_outs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        send_word(vecs[7]);

        repeat (12) @(negedge clk);
        check("scoreboard_drained", 32'(bq.size() + dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in serial-out transmitter built from D flip-flops. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a serial line, with a qualifier and a completion pulse. It is the driving end for serial-in capture blocks in the sequential_circuit library. It supports gapless back-to-back words.

Parameters:
WIDTH, 8, word length in bits; legal values are >= 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  rising-edge clock; the only clock.
resetn  input  1  asynchronous, active-low reset.
load_valid  input  1  load_data is presented for transfer.
load_data  input  WIDTH  word to transmit; sampled only on acceptance.
load_ready  output  1  block can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a live data bit.
done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous, active-low on resetn. Assertion takes effect immediately, not at the next clock edge.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, sout = 0, sout_valid = 0, done = 0, load_ready = 1.
- FSM states:
  - IDLE: no word in flight.
  - SHIFT: word in flight.
- Bit counter: width $clog2(WIDTH). It counts bits already sent in the current word.
- load_ready (combinational from registered state):
  - 1 in IDLE.
  - 1 in SHIFT when counter == WIDTH-1 (last bit cycle).
  - 0 otherwise.
- Accept event: load_valid && load_ready at a rising clk edge. On accept: shift register <= load_data, counter <= 0, state <= SHIFT.
- load_data and load_valid are ignored while load_ready = 0. No buffering; the word is not captured later.
- SHIFT operation:
  - sout = shift register bit WIDTH-1 when MSB_FIRST = 1, else bit 0.
  - sout_valid = 1.
  - At each edge, shift toward the output end with zero fill, and counter increments.
- Last bit (counter == WIDTH-1 at an edge):
  - done <= 1 for exactly one cycle.
  - With a simultaneous accept: reload, counter <= 0, stay in SHIFT. No idle gap; sout_valid stays 1.
  - Without an accept: state <= IDLE.
- IDLE outputs: sout = 0, sout_valid = 0.
- Latency:
  - Word accepted at edge N: bit 0 of the frame is on sout from N until N+1. The last bit is on sout from N+WIDTH-1 until N+WIDTH.
  - done is high from N+WIDTH until N+WIDTH+1.
- Back-to-back words: done for word k is high during the first bit of word k+1.
- Reset mid-frame:
  - Frame aborts immediately; all outputs take their reset values.
  - No done pulse for the aborted word.
  - After resetn returns high, the first edge with load_valid = 1 accepts a new word.
- load_valid held high continuously gives continuous words, each WIDTH cycles, with no gaps.
- Counter overflow: the counter never exceeds WIDTH-1. It wraps only through reload or return to IDLE.

Test Plan:
1. Reset check: resetn = 0 with random inputs and a free-running clk -> sout = 0, sout_valid = 0, done = 0, load_ready = 1. After release, nothing transmits until load_valid = 1.
2. Single word, WIDTH = 8, MSB_FIRST = 1: load 8'hA5 for one cycle.
   - sout over 8 cycles = 1,0,1,0,0,1,0,1.
   - sout_valid high for exactly 8 cycles; load_ready low for cycles 1-7.
   - done high for 1 cycle after the last bit, then IDLE.
3. Back-to-back, WIDTH = 8, MSB_FIRST = 1: 8'hA5, then 8'h3C offered during the last bit.
   - 16 contiguous valid bits: 10100101 then 00111100.
   - done pulses at bit 0 of the second word and after bit 15.
4. LSB-first, MSB_FIRST = 0: load 8'h01 -> sout = 1,0,0,0,0,0,0,0.
5. Load during busy: load_valid with 8'hFF asserted during cycles 2-5 of an 8'hA5 frame -> ignored. The frame completes unchanged, then the block returns to IDLE (load_valid deasserted by then).
6. Reset mid-frame: resetn = 0 during bit 3 of 8'hA5 -> outputs 0 immediately and no done pulse. After release, a new 8'h0F loads and transmits in full, with its own done pulse.
